// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the AES round sequencer.
//   aes_seq_state_t : sequencer FSM states
//   aes_mode_t      : key-size selector as seen on the mode input
//   NR_128/192/256  : number of cipher rounds per key size
//   nr_of()         : maps a mode to its round count
// ---------------------------------------------------------------------------
package aes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KEYGEN = 3'd1,
      ST_INIT   = 3'd2,
      ST_ROUND  = 3'd3,
      ST_FINAL  = 3'd4,
      ST_DONE   = 3'd5
   } aes_seq_state_t;

   typedef enum logic [1:0] {
      MODE_128 = 2'b00,
      MODE_192 = 2'b01,
      MODE_256 = 2'b10,
      MODE_ILL = 2'b11
   } aes_mode_t;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   // The illegal encoding never gets latched, so its return value only
   // matters for keeping the decode total.
   function automatic logic [3:0] nr_of(input aes_mode_t m);
      logic [3:0] nr;
      nr = NR_128;
      case (m)
         MODE_192: nr = NR_192;
         MODE_256: nr = NR_256;
         default:  nr = NR_128;
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// ---------------------------------------------------------------------------
// aes_round_cnt
// Round counter for the AES sequencer: clear, load, increment, and a
// terminal-count flag raised when the count sits at the penultimate round.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_clr        : force count to zero (highest priority after reset)
//   i_load       : load i_nr into the count
//   i_en         : increment the count
//   i_nr         : round count Nr of the current key size
//   o_count      : current round number
//   o_tc         : count == Nr-1
// ---------------------------------------------------------------------------
module aes_round_cnt #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_nr,
   output logic [W-1:0] o_count,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   // Clear wins over load, load wins over increment; the sequencer never
   // asserts more than one at a time, but the priority keeps it defined.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_nr;
      end else if (i_en) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == (i_nr - W'(1)));

endmodule

// File: rtl/aes_round_seq.sv
// ---------------------------------------------------------------------------
// aes_round_seq
// AES control unit: runs key expansion when needed, then sequences the
// INIT / ROUND / FINAL steps of one block for AES-128/192/256, in either
// direction, with a start/busy/done handshake and a global stall.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : request a block (sampled in IDLE or DONE)
//   i_mode         : key size, 11 is rejected with o_err
//   i_dec          : decrypt request, latched at start
//   i_new_key      : key changed, forces key expansion
//   i_kexp_done    : key-expansion unit finished (sampled in KEYGEN)
//   i_hold         : stall everything
//   o_genk         : key-expansion enable
//   o_enc          : round datapath enable
//   o_mix_en       : (Inv)MixColumns enable
//   o_last         : final round marker
//   o_round        : current round number
//   o_rk_idx       : round-key index (reversed for decrypt)
//   o_busy, o_done : handshake status
//   o_err          : one-cycle pulse on an illegal-mode start
// ---------------------------------------------------------------------------
module aes_round_seq
   import aes_pkg::*;
#(
   parameter int ROUND_W  = 4,
   parameter bit DEC_EN   = 1'b1,
   parameter bit REUSE_EN = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [1:0]         i_mode,
   input  logic               i_dec,
   input  logic               i_new_key,
   input  logic               i_kexp_done,
   input  logic               i_hold,
   output logic               o_genk,
   output logic               o_enc,
   output logic               o_mix_en,
   output logic               o_last,
   output logic [ROUND_W-1:0] o_round,
   output logic [ROUND_W-1:0] o_rk_idx,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);

   aes_seq_state_t r_state;
   aes_seq_state_t w_nextState;
   aes_mode_t      r_mode;
   aes_mode_t      r_keyMode;
   aes_mode_t      w_reqMode;
   logic           r_dec;
   logic           r_keyOk;
   logic           r_err;

   logic               w_accept;
   logic               w_errReq;
   logic               w_needKeygen;
   logic               w_keyLearn;
   logic               w_cntClr;
   logic               w_cntEn;
   logic               w_cntLoad;
   logic               w_tc;
   logic [ROUND_W-1:0] w_nr;
   logic [ROUND_W-1:0] w_round;

   assign w_reqMode = aes_mode_t'(i_mode);
   assign w_nr      = ROUND_W'(nr_of(r_mode));

   // The expanded key can be reused only if a previous expansion completed
   // for the same key size and the host says the key itself is unchanged.
   assign w_needKeygen = i_new_key || !REUSE_EN || !r_keyOk ||
                         (w_reqMode != r_keyMode);

   aes_round_cnt #(
      .W (ROUND_W)
   ) u_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_cntClr),
      .i_load  (w_cntLoad),
      .i_en    (w_cntEn),
      .i_nr    (w_nr),
      .o_count (w_round),
      .o_tc    (w_tc)
   );

   // State register; hold is folded into the next-state logic, so the
   // register simply follows w_nextState.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and counter control. Nothing advances while held, which
   // also keeps start and kexp_done unsampled during a stall. DONE always
   // leaves after one cycle, either back to IDLE or straight into the next
   // block when a valid start arrives.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_errReq    = 1'b0;
      w_keyLearn  = 1'b0;
      w_cntClr    = 1'b0;
      w_cntEn     = 1'b0;
      w_cntLoad   = 1'b0;
      if (!i_hold) begin
         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               w_nextState = ST_IDLE;
               if (i_start) begin
                  if (w_reqMode == MODE_ILL) begin
                     w_errReq = 1'b1;
                  end else begin
                     w_accept    = 1'b1;
                     w_cntClr    = 1'b1;
                     w_nextState = w_needKeygen ? ST_KEYGEN : ST_INIT;
                  end
               end
            end
            ST_KEYGEN: begin
               if (i_kexp_done) begin
                  w_keyLearn  = 1'b1;
                  w_nextState = ST_INIT;
               end
            end
            ST_INIT: begin
               w_cntEn     = 1'b1;
               w_nextState = ST_ROUND;
            end
            ST_ROUND: begin
               if (w_tc) begin
                  w_cntLoad   = 1'b1;
                  w_nextState = ST_FINAL;
               end else begin
                  w_cntEn = 1'b1;
               end
            end
            ST_FINAL: begin
               w_nextState = ST_DONE;
            end
            default: begin
               w_nextState = ST_IDLE;
            end
         endcase
      end
   end

   // Request latches and key bookkeeping. The datapath works from these
   // copies, so the host may change its inputs freely once a block starts.
   // The error flag is rewritten every cycle so it is always a single pulse,
   // even if a stall begins right after it is raised.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mode    <= MODE_128;
         r_dec     <= 1'b0;
         r_keyOk   <= 1'b0;
         r_keyMode <= MODE_128;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_errReq;
         if (w_accept) begin
            r_mode <= w_reqMode;
            r_dec  <= DEC_EN ? i_dec : 1'b0;
         end
         if (w_keyLearn) begin
            r_keyOk   <= 1'b1;
            r_keyMode <= r_mode;
         end
      end
   end

   // Output decode from registered state only.
   assign o_genk   = (r_state == ST_KEYGEN);
   assign o_enc    = (r_state == ST_INIT) || (r_state == ST_ROUND) ||
                     (r_state == ST_FINAL);
   assign o_mix_en = (r_state == ST_ROUND);
   assign o_last   = (r_state == ST_FINAL);
   assign o_busy   = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign o_done   = (r_state == ST_DONE);
   assign o_err    = r_err;
   assign o_round  = w_round;
   assign o_rk_idx = r_dec ? (w_nr - w_round) : w_round;

endmodule

// File: tb/tb_aes_round_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_round_seq
// Directed bench for aes_round_seq. Each block is walked cycle by cycle and
// every cycle's outputs are compared against the sequence expected for the
// requested key size, direction and key-expansion length.
// ---------------------------------------------------------------------------
module tb_aes_round_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic       dec;
   logic       newKey;
   logic       kexpDone;
   logic       hold;
   logic       genk;
   logic       enc;
   logic       mixEn;
   logic       last;
   logic [3:0] round;
   logic [3:0] rkIdx;
   logic       busy;
   logic       done;
   logic       err;

   int errCount;
   int checkCount;
   int cycleCount;

   aes_round_seq #(
      .ROUND_W  (4),
      .DEC_EN   (1'b1),
      .REUSE_EN (1'b1)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_mode      (mode),
      .i_dec       (dec),
      .i_new_key   (newKey),
      .i_kexp_done (kexpDone),
      .i_hold      (hold),
      .o_genk      (genk),
      .o_enc       (enc),
      .o_mix_en    (mixEn),
      .o_last      (last),
      .o_round     (round),
      .o_rk_idx    (rkIdx),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control bits packed as {genk, enc, mix_en, last, busy, done, err}.
   localparam logic [6:0] C_IDLE   = 7'b0000000;
   localparam logic [6:0] C_KEYGEN = 7'b1000100;
   localparam logic [6:0] C_INIT   = 7'b0100100;
   localparam logic [6:0] C_ROUND  = 7'b0110100;
   localparam logic [6:0] C_FINAL  = 7'b0101100;
   localparam logic [6:0] C_DONE   = 7'b0000010;
   localparam logic [6:0] C_ERR    = 7'b0000001;

   function automatic logic [31:0] ctrlNow();
      return {25'd0, genk, enc, mixEn, last, busy, done, err};
   endfunction

   function automatic logic [31:0] idxNow();
      return {24'd0, round, rkIdx};
   endfunction

   // Expected {round, rk_idx} pair for a given round and direction.
   function automatic logic [31:0] idxExp(input int r, input logic d, input int nr);
      int rk;
      rk = d ? (nr - r) : r;
      return {24'd0, r[3:0], rk[3:0]};
   endfunction

   // Advance one clock and settle just after the edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      cycleCount++;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)",
                  tag, observed, expected, cycleCount);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [1:0] m,
                                input logic d, input logic nk);
      start  = s;
      mode   = m;
      dec    = d;
      newKey = nk;
   endtask

   // Apply reset for one edge and expect everything back to zero.
   task automatic resetNow(input string tag);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput({tag, "_ctrl"}, ctrlNow(), {25'd0, C_IDLE});
      checkOutput({tag, "_idx"}, idxNow(), 32'd0);
   endtask

   // Run one block from IDLE. kgLen=0 means key expansion must be skipped.
   // holdAt/holdLen stall at a round; abortKg/abortRound reset mid-block.
   task automatic runBlock(input logic [1:0] m, input logic d, input logic nk,
                           input int kgLen, input int nr,
                           input int holdAt, input int holdLen,
                           input int abortKg, input int abortRound);
      int startCyc;
      startCyc = cycleCount;
      applyStimulus(1'b1, m, d, nk);
      stepCycle();
      // Scramble the request inputs while busy; the latched copies must win.
      applyStimulus(1'b0, 2'b11, ~d, ~nk);
      for (int k = 1; k <= kgLen; k++) begin
         checkOutput("keygen_ctrl", ctrlNow(), {25'd0, C_KEYGEN});
         checkOutput("keygen_idx", idxNow(), idxExp(0, d, nr));
         if (k == abortKg) begin
            resetNow("rst_keygen");
            return;
         end
         if (k == kgLen) kexpDone = 1'b1;
         stepCycle();
         kexpDone = 1'b0;
      end
      checkOutput("init_ctrl", ctrlNow(), {25'd0, C_INIT});
      checkOutput("init_idx", idxNow(), idxExp(0, d, nr));
      stepCycle();
      for (int r = 1; r < nr; r++) begin
         checkOutput("round_ctrl", ctrlNow(), {25'd0, C_ROUND});
         checkOutput("round_idx", idxNow(), idxExp(r, d, nr));
         if (r == abortRound) begin
            resetNow("rst_round");
            return;
         end
         if (r == holdAt) begin
            hold = 1'b1;
            for (int h = 0; h < holdLen; h++) begin
               stepCycle();
               checkOutput("hold_ctrl", ctrlNow(), {25'd0, C_ROUND});
               checkOutput("hold_idx", idxNow(), idxExp(r, d, nr));
            end
            hold = 1'b0;
         end
         stepCycle();
      end
      checkOutput("final_ctrl", ctrlNow(), {25'd0, C_FINAL});
      checkOutput("final_idx", idxNow(), idxExp(nr, d, nr));
      stepCycle();
      checkOutput("done_ctrl", ctrlNow(), {25'd0, C_DONE});
      checkOutput("latency", 32'(cycleCount - startCyc), 32'(nr + 2 + kgLen + holdLen));
      stepCycle();
      checkOutput("idle_ctrl", ctrlNow(), {25'd0, C_IDLE});
   endtask

   initial begin
      errCount   = 0;
      checkCount = 0;
      cycleCount = 0;
      rst        = 1'b0;
      kexpDone   = 1'b0;
      hold       = 1'b0;
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

      $display("[TB] reset");
      rst = 1'b1;
      stepCycle();
      resetNow("reset");

      $display("[TB] AES-128 encrypt with key expansion");
      runBlock(2'b00, 1'b0, 1'b1, 3, 10, 0, 0, 0, 0);

      $display("[TB] AES-256 decrypt, then key reuse");
      runBlock(2'b10, 1'b1, 1'b1, 2, 14, 0, 0, 0, 0);
      runBlock(2'b10, 1'b1, 1'b0, 0, 14, 0, 0, 0, 0);

      $display("[TB] key reuse with mode change");
      runBlock(2'b00, 1'b0, 1'b1, 1, 10, 0, 0, 0, 0);
      runBlock(2'b01, 1'b0, 1'b0, 2, 12, 0, 0, 0, 0);

      $display("[TB] illegal mode");
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("err_ctrl", ctrlNow(), {25'd0, C_ERR});
      stepCycle();
      checkOutput("err_clear", ctrlNow(), {25'd0, C_IDLE});

      $display("[TB] hold at round 5");
      runBlock(2'b00, 1'b0, 1'b1, 1, 10, 5, 4, 0, 0);

      $display("[TB] reset mid-round and mid-keygen");
      runBlock(2'b00, 1'b0, 1'b0, 0, 10, 0, 0, 0, 7);
      runBlock(2'b00, 1'b0, 1'b0, 2, 10, 0, 0, 1, 0);
      runBlock(2'b00, 1'b0, 1'b0, 2, 10, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
